// File: rtl/alu_shift_pkg.sv
// Shared encodings and default widths for the iterative ALU shifter.
// SHIFTER_RADIX4_EN selects the 4-bit-per-step variant in dependent files.
package alu_shift_pkg;

    localparam int DEF_OPERAND_WIDTH = 32;
    localparam int DEF_SA_WIDTH      = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_shift_step.sv
// One combinational shift step: by 1, or by 4 when built with SHIFTER_RADIX4_EN.
// The amount is chosen by the caller; this block only moves bits.
module alu_shift_step
    import alu_shift_pkg::*;
#(
    parameter int operand_width = DEF_OPERAND_WIDTH
) (
    input  logic [operand_width-1:0] i_data,
    input  op_e                      i_op,
`ifdef SHIFTER_RADIX4_EN
    input  logic                     i_by4,
`endif
    output logic [operand_width-1:0] o_data
);

    localparam int W = operand_width;

    logic w_msb;
    assign w_msb = i_data[W-1];

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL:  o_data = {i_data[W-2:0], 1'b0};
            OP_SRL:  o_data = {1'b0, i_data[W-1:1]};
            OP_SRA:  o_data = {w_msb, i_data[W-1:1]};
            default: o_data = i_data;
        endcase
`ifdef SHIFTER_RADIX4_EN
        if (i_by4) begin
            case (i_op)
                OP_SLL:  o_data = {i_data[W-5:0], 4'b0000};
                OP_SRL:  o_data = {4'b0000, i_data[W-1:4]};
                OP_SRA:  o_data = {{4{w_msb}}, i_data[W-1:4]};
                default: o_data = i_data;
            endcase
        end
`endif
    end

endmodule

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: FSM, step count and result registers around alu_shift_step.
// SHIFTER_RADIX4_EN enables 4-bit steps while at least 4 positions remain.
module alu_iter_shifter
    import alu_shift_pkg::*;
#(
    parameter int operand_width = DEF_OPERAND_WIDTH,
    parameter int Sa_width      = DEF_SA_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [1:0]               op_in,
    input  logic [operand_width-1:0] operand_in,
    input  logic [Sa_width-1:0]      Sa_in,
    input  logic                     flush_in,
    output logic                     busy_out,
    output logic                     valid_out,
    output logic [operand_width-1:0] result_out
);

    state_e                     r_state;
    op_e                        r_op;
    logic [operand_width-1:0]   r_work;
    logic [Sa_width-1:0]        r_count;
    logic                       r_busy;
    logic                       r_valid;
    logic [operand_width-1:0]   r_result;

    logic                       w_accept;
    logic                       w_pass;
    op_e                        w_op;
    logic [operand_width-1:0]   w_step_in;
    logic [operand_width-1:0]   w_step_out;
    logic [Sa_width-1:0]        w_cnt;
    logic [Sa_width-1:0]        w_dec;
    logic [Sa_width-1:0]        w_rem;

    assign w_accept  = start_in && (r_state != SHIFT);
    assign w_pass    = (op_e'(op_in) == OP_PASS) || (Sa_in == '0);
    assign w_op      = w_accept ? op_e'(op_in) : r_op;
    assign w_step_in = w_accept ? operand_in : r_work;
    assign w_cnt     = w_accept ? Sa_in : r_count;

    // The accepting edge already performs the first step, so latency equals step count.
`ifdef SHIFTER_RADIX4_EN
    logic w_by4;
    assign w_by4 = (w_cnt >= Sa_width'(4));
    assign w_dec = w_by4 ? Sa_width'(4) : Sa_width'(1);
`else
    assign w_dec = Sa_width'(1);
`endif
    assign w_rem = w_cnt - w_dec;

    alu_shift_step #(
        .operand_width(operand_width)
    ) u_step (
        .i_data (w_step_in),
        .i_op   (w_op),
`ifdef SHIFTER_RADIX4_EN
        .i_by4  (w_by4),
`endif
        .o_data (w_step_out)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= IDLE;
            r_op     <= OP_SLL;
            r_work   <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (flush_in) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_op <= op_e'(op_in);
                if (w_pass) begin
                    r_state  <= DONE;
                    r_result <= operand_in;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_count  <= '0;
                end else if (w_rem == '0) begin
                    r_state  <= DONE;
                    r_result <= w_step_out;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_count  <= '0;
                end else begin
                    r_state <= SHIFT;
                    r_work  <= w_step_out;
                    r_count <= w_rem;
                    r_busy  <= 1'b1;
                end
            end else begin
                case (r_state)
                    SHIFT: begin
                        r_work  <= w_step_out;
                        r_count <= w_rem;
                        if (w_rem == '0) begin
                            r_state  <= DONE;
                            r_result <= w_step_out;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy_out   = r_busy;
    assign valid_out  = r_valid;
    assign result_out = r_result;

endmodule

// File: tb/tb_alu_iter_shifter.sv
// Self-checking bench for alu_iter_shifter: directed table, corner sequences, random ops.
// Build with SHIFTER_RADIX4_EN defined to check the radix-4 variant.
module tb_alu_iter_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  sa;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_vec;
    int n_err;
    logic [31:0] last_res;

    alu_iter_shifter dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start),
        .op_in      (op),
        .operand_in (operand),
        .Sa_in      (sa),
        .flush_in   (flush),
        .busy_out   (busy),
        .valid_out  (valid),
        .result_out (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] opnd;
        int          sa;
        logic [31:0] exp;
        int          lat;
    } vec_t;

`ifdef SHIFTER_RADIX4_EN
    localparam int L31 = 10;
    localparam int L4  = 1;
`else
    localparam int L31 = 31;
    localparam int L4  = 4;
`endif

    // Reference: the architectural meaning of each op, not the step-by-step datapath.
    function automatic logic [31:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input int s);
        logic signed [31:0] sx;
        sx = x;
        case (o)
            2'd0:    return x << s;
            2'd1:    return x >> s;
            2'd2:    return sx >>> s;
            default: return x;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input int s);
        int l;
        if (s == 0 || o == 2'd3) return 1;
`ifdef SHIFTER_RADIX4_EN
        l = s / 4 + s % 4;
        return (l < 1) ? 1 : l;
`else
        l = s;
        return l;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] x,
                            input int s);
        start   = 1'b1;
        op      = o;
        operand = x;
        sa      = 5'(s);
    endtask

    // Called at the negedge where start was driven; returns at the valid negedge.
    task automatic wait_result(input string nm, input logic [31:0] exp,
                               input int lat);
        int k;
        bit seen;
        bit busy_ok;
        k = 0;
        seen = 0;
        busy_ok = 1;
        while (!seen && k < 80) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (valid) begin
                seen = 1;
                if (busy) busy_ok = 0;
            end else if (!busy) begin
                busy_ok = 0;
            end
        end
        check({nm, "_lat"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(lat));
        check({nm, "_res"}, result, exp);
        check({nm, "_busy"}, 32'(busy_ok), 32'd1);
        last_res = exp;
    endtask

    vec_t tbl[9];

    initial begin
        int k;
        bit seen;
        logic [1:0]  ro;
        logic [31:0] rx;
        int          rs;

        n_vec = 0;
        n_err = 0;
        last_res = '0;
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'd0;
        operand = '0;
        sa = '0;

        tbl[0] = '{2'd0, 32'h0000_0001, 31, 32'h8000_0000, L31};
        tbl[1] = '{2'd2, 32'h8000_0000, 4,  32'hF800_0000, L4};
        tbl[2] = '{2'd1, 32'h8000_0000, 4,  32'h0800_0000, L4};
        tbl[3] = '{2'd0, 32'h1234_5678, 0,  32'h1234_5678, 1};
        tbl[4] = '{2'd1, 32'h1234_5678, 0,  32'h1234_5678, 1};
        tbl[5] = '{2'd2, 32'h1234_5678, 0,  32'h1234_5678, 1};
        tbl[6] = '{2'd3, 32'h1234_5678, 7,  32'h1234_5678, 1};
        tbl[7] = '{2'd2, 32'h7FFF_0000, 1,  32'h3FFF_8000, 1};
        tbl[8] = '{2'd1, 32'hFFFF_FFFF, 31, 32'h0000_0001, L31};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", result, 32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            check("tbl_drop", 32'(valid), 32'd0);
            start_op(tbl[i].op, tbl[i].opnd, tbl[i].sa);
            wait_result($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].lat);
        end

        // Back-to-back: each start lands in the previous DONE cycle.
        @(negedge clk);
        start_op(2'd1, 32'hF000_0000, 3);
        wait_result("b2b_a", 32'h1E00_0000, ref_lat(2'd1, 3));
        start_op(2'd0, 32'h1234_5678, 0);
        wait_result("b2b_b", 32'h1234_5678, 1);
        start_op(2'd2, 32'h8000_0000, 4);
        wait_result("b2b_c", 32'hF800_0000, L4);
        @(negedge clk);
        check("b2b_drop", 32'(valid), 32'd0);

        // A second start while busy must be ignored.
        start_op(2'd1, 32'hDEAD_BEEF, 10);
        k = 0;
        seen = 0;
        while (!seen && k < 80) begin
            @(negedge clk);
            k++;
            start = (k == 3);
            if (k == 3) begin
                op = 2'd0;
                operand = 32'h0000_0001;
                sa = 5'd1;
            end
            if (valid) seen = 1;
        end
        check("ign_lat", seen ? 32'(k) : 32'hFFFF_FFFF, 32'(ref_lat(2'd1, 10)));
        check("ign_res", result, 32'h0037_AB6F);
        last_res = 32'h0037_AB6F;
        start = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        check("ign_no_valid", 32'(seen), 32'd0);

        // Flush mid-operation: back to idle, result holds, no pulse.
        start_op(2'd0, 32'h0000_0001, 20);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_hold", result, last_res);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid || busy) seen = 1;
        end
        check("flush_quiet", 32'(seen), 32'd0);

        // Flush and start together: flush wins.
        start_op(2'd0, 32'hAAAA_5555, 0);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("fs_valid", 32'(valid), 32'd0);
        check("fs_result", result, last_res);
        @(negedge clk);
        check("fs_valid2", 32'(valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            rs = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                check("rnd_drop", 32'(valid), 32'd0);
            end
            start_op(ro, rx, rs);
            wait_result($sformatf("rnd%0d", i), ref_res(ro, rx, rs), ref_lat(ro, rs));
        end

        // Reset mid-operation: clears result and aborts.
        @(negedge clk);
        start_op(2'd1, 32'hFFFF_0000, 20);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_result", result, 32'd0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid || busy) seen = 1;
        end
        check("mrst_quiet", 32'(seen), 32'd0);

        start_op(2'd0, 32'h0000_0003, 2);
        wait_result("post_rst", 32'h0000_000C, ref_lat(2'd0, 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_iter_shifter.md
ALU_ITER_SHIFTER -- requirements
Module: alu_iter_shifter

Interface
REQ-001 SHALL have parameter: operand_width, 32, width of operand and result.
REQ-002 SHALL have parameter: Sa_width, 5, width of shift amount.
REQ-003 SHALL have port: clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst_in  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port: start_in  input  1  request to begin a shift.
REQ-006 SHALL have port: op_in  input  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
REQ-007 SHALL have port: operand_in  input  operand_width  value to shift.
REQ-008 SHALL have port: Sa_in  input  Sa_width  shift amount from the shift-amount generator.
REQ-009 SHALL have port: flush_in  input  1  abort the current operation.
REQ-010 SHALL have port: busy_out  output  1  high while shifting; start_in ignored.
REQ-011 SHALL have port: valid_out  output  1  one-cycle pulse; result_out valid.
REQ-012 SHALL have port: result_out  output  operand_width  shifted result; registered.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL accept start_in only in IDLE or DONE (busy_out=0); on that edge, latch op_in, operand_in and Sa_in into working and count registers.
REQ-015 On accept with Sa_in=0 or op_in=11, SHALL go to DONE: result_out=operand_in, valid_out=1 at the next cycle (latency 1).
REQ-016 On accept with Sa_in=N>=1 and op_in!=11, SHALL go to SHIFT; busy_out=1.
REQ-017 In SHIFT, each edge SHALL shift by 1 and decrement count: SLL zero-fill LSB, SRL zero-fill MSB, SRA replicate bit operand_width-1.
REQ-018 On the edge where count reaches 0, SHALL go to DONE with result_out=final value and valid_out=1; latency from accept = N cycles.
REQ-019 DONE SHALL last one cycle: next edge to SHIFT/DONE if start_in accepted (back-to-back), else IDLE; valid_out drops unless a new Sa=0 result completes.
REQ-020 start_in while busy_out=1 SHALL be ignored with no effect on the operation in progress.
REQ-021 flush_in=1 in any state SHALL force IDLE on the next edge with busy_out=0, valid_out=0; result_out holds.
REQ-022 Simultaneous flush_in and start_in: flush wins, start dropped.
REQ-023 result_out SHALL hold its last value outside DONE; consumers sample only when valid_out=1.

Reset
REQ-024 rst_in=1 at an edge SHALL force IDLE, busy_out=0, valid_out=0, result_out=0, count=0, and abort any operation in progress, with priority over flush_in and start_in.

Configuration
REQ-025 Macro SHIFTER_RADIX4_EN defined: each SHIFT edge SHALL shift by 4 when count>=4, else by 1; latency = floor(N/4)+(N mod 4), minimum 1.
REQ-026 Macro SHIFTER_RADIX4_EN undefined: SHALL shift by 1 per edge only; no radix-4 logic present.

Structure
REQ-027 Shared package alu_shift_pkg SHALL hold op_in encodings, FSM state encoding, and default widths 32/5.
REQ-028 One combinational sub-module alu_shift_step SHALL compute a single step (by 1, or by 4 when enabled) for the given op; the top holds FSM, count and registers.

Verification
REQ-029 SLL, operand 0x0000_0001, Sa 31 -> busy_out high 31 cycles, valid_out at cycle 31, result 0x8000_0000 (radix-4: cycle 10).
REQ-030 SRA 0x8000_0000 Sa 4 -> 0xF800_0000 at cycle 4; SRL same inputs -> 0x0800_0000 (radix-4: cycle 1).
REQ-031 Sa 0, operand 0x1234_5678, any op; and op 11, Sa 7 -> valid_out at cycle 1, result 0x1234_5678.
REQ-032 Start SRL Sa 10, second start at cycle 3 with other operands -> second ignored, first result correct at cycle 10.
REQ-033 Flush at cycle 5 of Sa 20, or rst_in at cycle 5 -> IDLE next cycle, no valid_out; rst_in also zeroes result_out.
REQ-034 Back-to-back: start in the DONE cycle -> accepted; two correct valid_out pulses with no idle gap.
